// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-bit-opcode CPU: opcodes, ALU operation codes and
// instruction field positions, plus small field-extraction helpers.
package cpu_pkg;

   typedef enum logic [2:0] {
      OPC_ADD  = 3'd0,
      OPC_SUB  = 3'd1,
      OPC_DIV  = 3'd2,
      OPC_MUL  = 3'd3,
      OPC_MCLR = 3'd4,
      OPC_HALT = 3'd5,
      OPC_MRD  = 3'd6,
      OPC_MWR  = 3'd7
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_DIV = 4'd2,
      ALU_MUL = 4'd3,
      ALU_AND = 4'd4,
      ALU_OR  = 4'd5,
      ALU_XOR = 4'd6,
      ALU_SLT = 4'd7
   } alu_op_e;

   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 29;
   localparam int unsigned SRC_MSB = 28;
   localparam int unsigned SRC_LSB = 27;
   localparam int unsigned DST_MSB = 26;
   localparam int unsigned DST_LSB = 25;
   localparam int unsigned IMM_MSB = 24;
   localparam int unsigned IMM_LSB = 0;

   function automatic logic [2:0] get_opcode(input logic [31:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [1:0] get_src(input logic [31:0] instr);
      return instr[SRC_MSB:SRC_LSB];
   endfunction

   function automatic logic [1:0] get_dst(input logic [31:0] instr);
      return instr[DST_MSB:DST_LSB];
   endfunction

   function automatic logic [24:0] get_imm(input logic [31:0] instr);
      return instr[IMM_MSB:IMM_LSB];
   endfunction

endpackage

// File: rtl/alu_mem_reg_core_alu.sv
// Combinational 32-bit ALU. Codes 8-15 are unused and produce 0; divide by zero
// saturates to all ones.
module alu
   import cpu_pkg::*;
(
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic [3:0]  op,
   output logic [31:0] rd
);

   always_comb begin
      rd = '0;
      case (op)
         ALU_ADD: rd = rs + rt;
         ALU_SUB: rd = rs - rt;
         ALU_DIV: rd = (rt == '0) ? '1 : rs / rt;
         ALU_MUL: rd = rs * rt;
         ALU_AND: rd = rs & rt;
         ALU_OR:  rd = rs | rt;
         ALU_XOR: rd = rs ^ rt;
         ALU_SLT: rd = {31'd0, $signed(rs) < $signed(rt)};
         default: rd = '0;
      endcase
   end

endmodule

// File: rtl/alu_mem_reg_core.sv
// Datapath core: ALU, 4x32 register bank and dual-port word memory, each with
// independently exposed ports for the sequencer to drive.
module alu_mem_reg_core
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned AW        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_clear,
   input  logic        op2_en,
   input  logic        op2_rw,
   input  logic [31:0] read_pc,
   input  logic [31:0] rw_addr,
   input  logic [31:0] data_write,
   output logic [31:0] instruction,
   output logic [31:0] data_read,
   input  logic        opwrite,
   input  logic [1:0]  reg_write,
   input  logic [1:0]  src_1,
   input  logic [1:0]  src_2,
   input  logic [31:0] reg_data,
   output logic [31:0] data_src_1,
   output logic [31:0] data_src_2,
   input  logic [31:0] alu_rs,
   input  logic [31:0] alu_rt,
   input  logic [3:0]  alu_op,
   output logic [31:0] alu_rd
);

   logic [31:0] regs [4];
   logic [31:0] mem  [MEM_DEPTH];

   logic [AW-1:0] pc_idx;
   logic [AW-1:0] rw_idx;
   logic          mem_wr;
   logic          mem_rd;
   logic          unused_addr_bits;

   // Upper address bits are deliberately dropped so addresses wrap modulo MEM_DEPTH.
   assign pc_idx           = read_pc[AW-1:0];
   assign rw_idx           = rw_addr[AW-1:0];
   assign unused_addr_bits = ^{read_pc[31:AW], rw_addr[31:AW]};

   assign mem_wr = op2_en & op2_rw;
   assign mem_rd = op2_en & ~op2_rw;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      end else if (opwrite) begin
         regs[reg_write] <= reg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || m_clear) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (mem_wr) begin
         mem[rw_idx] <= data_write;
      end
   end

   assign data_src_1  = regs[src_1];
   assign data_src_2  = regs[src_2];
   assign instruction = mem[pc_idx];
   assign data_read   = mem_rd ? mem[rw_idx] : '0;

   alu u_alu (
      .rs (alu_rs),
      .rt (alu_rt),
      .op (alu_op),
      .rd (alu_rd)
   );

endmodule

// File: tb/tb_alu_mem_reg_core.sv
// Scoreboard bench for alu_mem_reg_core: expectations are queued when stimulus is
// applied and popped when the corresponding output is sampled.
module tb_alu_mem_reg_core;
   import cpu_pkg::*;

   localparam int unsigned MEM_DEPTH = 256;
   localparam int unsigned AW        = 8;

   logic        clk = 1'b0;
   logic        rst, m_clear, op2_en, op2_rw, opwrite;
   logic [31:0] read_pc, rw_addr, data_write, instruction, data_read;
   logic [1:0]  reg_write, src_1, src_2;
   logic [31:0] reg_data, data_src_1, data_src_2;
   logic [31:0] alu_rs, alu_rt, alu_rd;
   logic [3:0]  alu_op;

   int unsigned compared   = 0;
   int unsigned mismatched = 0;
   logic [31:0] sb [$];
   logic [31:0] exp_v;

   always #5 clk = ~clk;

   alu_mem_reg_core #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .m_clear(m_clear), .op2_en(op2_en), .op2_rw(op2_rw),
      .read_pc(read_pc), .rw_addr(rw_addr), .data_write(data_write),
      .instruction(instruction), .data_read(data_read),
      .opwrite(opwrite), .reg_write(reg_write), .src_1(src_1), .src_2(src_2),
      .reg_data(reg_data), .data_src_1(data_src_1), .data_src_2(data_src_2),
      .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op), .alu_rd(alu_rd)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
      op2_en = 1'b1; op2_rw = 1'b1; rw_addr = a; data_write = d;
      tick();
      op2_en = 1'b0; op2_rw = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] addrs [3];
      addrs[0] = 32'd0; addrs[1] = 32'd5; addrs[2] = 32'd255;
      // dirty state first so the reset has something to clear
      opwrite = 1'b1; reg_write = 2'd1; reg_data = 32'h1111_1111; tick();
      reg_write = 2'd3; reg_data = 32'h3333_3333; tick();
      opwrite = 1'b0;
      mem_write(32'd5, 32'h5555_5555);
      mem_write(32'd255, 32'hFFFF_0000);
      rst = 1'b1; opwrite = 1'b1; reg_write = 2'd1; reg_data = 32'hBAD0_BAD0;
      tick();
      rst = 1'b0; opwrite = 1'b0;
      for (int r = 0; r < 4; r++) begin
         src_1 = 2'(r); src_2 = 2'(3 - r);
         sb.push_back(32'd0); sb.push_back(32'd0);
         #1;
         exp_v = sb.pop_front(); compared++;
         if (data_src_1 !== exp_v) begin
            mismatched++; $display("FAIL reset_reg src_1=%0d got %h want %h", r, data_src_1, exp_v);
         end
         exp_v = sb.pop_front(); compared++;
         if (data_src_2 !== exp_v) begin
            mismatched++; $display("FAIL reset_reg src_2=%0d got %h want %h", 3 - r, data_src_2, exp_v);
         end
      end
      op2_en = 1'b1; op2_rw = 1'b0;
      for (int k = 0; k < 3; k++) begin
         read_pc = addrs[k]; rw_addr = addrs[k];
         sb.push_back(32'd0); sb.push_back(32'd0);
         #1;
         exp_v = sb.pop_front(); compared++;
         if (instruction !== exp_v) begin
            mismatched++; $display("FAIL reset_mem_instr addr=%0d got %h want %h", addrs[k], instruction, exp_v);
         end
         exp_v = sb.pop_front(); compared++;
         if (data_read !== exp_v) begin
            mismatched++; $display("FAIL reset_mem_data addr=%0d got %h want %h", addrs[k], data_read, exp_v);
         end
      end
      op2_en = 1'b0;
   endtask

   task automatic test_mem_clear();
      mem_write(32'd5, 32'hA5A5_0001);
      read_pc = 32'd5;
      sb.push_back(32'hA5A5_0001);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (instruction !== exp_v) begin
         mismatched++; $display("FAIL clear_pre got %h want %h", instruction, exp_v);
      end
      // clear must win over a simultaneous write to the same word
      m_clear = 1'b1; op2_en = 1'b1; op2_rw = 1'b1; rw_addr = 32'd5; data_write = 32'h7777_7777;
      tick();
      m_clear = 1'b0; op2_rw = 1'b0;
      sb.push_back(32'd0); sb.push_back(32'd0);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (instruction !== exp_v) begin
         mismatched++; $display("FAIL clear_instr got %h want %h", instruction, exp_v);
      end
      exp_v = sb.pop_front(); compared++;
      if (data_read !== exp_v) begin
         mismatched++; $display("FAIL clear_data got %h want %h", data_read, exp_v);
      end
      op2_en = 1'b0;
   endtask

   task automatic test_alu();
      logic [3:0]  ops [13];
      logic [31:0] rss [13], rts [13], exps [13];
      ops[0]  = 4'd0;  rss[0]  = 32'hFFFF_FFFF; rts[0]  = 32'd1;        exps[0]  = 32'd0;
      ops[1]  = 4'd1;  rss[1]  = 32'd3;         rts[1]  = 32'd5;        exps[1]  = 32'hFFFF_FFFE;
      ops[2]  = 4'd3;  rss[2]  = 32'h1_0000;    rts[2]  = 32'h1_0000;   exps[2]  = 32'd0;
      ops[3]  = 4'd2;  rss[3]  = 32'd100;       rts[3]  = 32'd7;        exps[3]  = 32'd14;
      ops[4]  = 4'd2;  rss[4]  = 32'h1234_5678; rts[4]  = 32'd0;        exps[4]  = 32'hFFFF_FFFF;
      ops[5]  = 4'd12; rss[5]  = 32'hDEAD_BEEF; rts[5]  = 32'h1234;     exps[5]  = 32'd0;
      ops[6]  = 4'd4;  rss[6]  = 32'hF0F0_FF00; rts[6]  = 32'h0FF0_F0F0; exps[6] = 32'h00F0_F000;
      ops[7]  = 4'd5;  rss[7]  = 32'hF000_0001; rts[7]  = 32'h0000_0F00; exps[7] = 32'hF000_0F01;
      ops[8]  = 4'd6;  rss[8]  = 32'hFFFF_0000; rts[8]  = 32'hFF00_FF00; exps[8] = 32'h00FF_FF00;
      ops[9]  = 4'd7;  rss[9]  = 32'hFFFF_FFFF; rts[9]  = 32'd1;        exps[9]  = 32'd1;
      ops[10] = 4'd7;  rss[10] = 32'd1;         rts[10] = 32'hFFFF_FFFF; exps[10] = 32'd0;
      ops[11] = 4'd3;  rss[11] = 32'd12345;     rts[11] = 32'd678;      exps[11] = 32'd8369910;
      ops[12] = 4'd15; rss[12] = 32'd1;         rts[12] = 32'd1;        exps[12] = 32'd0;
      for (int i = 0; i < 13; i++) begin
         alu_op = ops[i]; alu_rs = rss[i]; alu_rt = rts[i];
         sb.push_back(exps[i]);
         #1;
         exp_v = sb.pop_front(); compared++;
         if (alu_rd !== exp_v) begin
            mismatched++;
            $display("FAIL alu op=%0d rs=%h rt=%h got %h want %h", ops[i], rss[i], rts[i], alu_rd, exp_v);
         end
      end
   endtask

   task automatic test_registers();
      src_1 = 2'd2; src_2 = 2'd2;
      opwrite = 1'b1; reg_write = 2'd2; reg_data = 32'h1234;
      sb.push_back(32'd0); sb.push_back(32'd0);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (data_src_1 !== exp_v) begin
         mismatched++; $display("FAIL reg_before_edge src_1 got %h want %h", data_src_1, exp_v);
      end
      exp_v = sb.pop_front(); compared++;
      if (data_src_2 !== exp_v) begin
         mismatched++; $display("FAIL reg_before_edge src_2 got %h want %h", data_src_2, exp_v);
      end
      tick();
      opwrite = 1'b0; reg_data = 32'h5555_AAAA;
      sb.push_back(32'h1234); sb.push_back(32'h1234);
      exp_v = sb.pop_front(); compared++;
      if (data_src_1 !== exp_v) begin
         mismatched++; $display("FAIL reg_after_edge src_1 got %h want %h", data_src_1, exp_v);
      end
      exp_v = sb.pop_front(); compared++;
      if (data_src_2 !== exp_v) begin
         mismatched++; $display("FAIL reg_after_edge src_2 got %h want %h", data_src_2, exp_v);
      end
      tick();
      src_1 = 2'd2; src_2 = 2'd0;
      sb.push_back(32'h1234); sb.push_back(32'd0);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (data_src_1 !== exp_v) begin
         mismatched++; $display("FAIL reg_no_write src_1 got %h want %h", data_src_1, exp_v);
      end
      exp_v = sb.pop_front(); compared++;
      if (data_src_2 !== exp_v) begin
         mismatched++; $display("FAIL reg_other src_2 got %h want %h", data_src_2, exp_v);
      end
   endtask

   task automatic test_data_port();
      mem_write(32'd3, 32'hDEAD_BEEF);
      op2_en = 1'b1; op2_rw = 1'b0; rw_addr = 32'd3;
      sb.push_back(32'hDEAD_BEEF);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (data_read !== exp_v) begin
         mismatched++; $display("FAIL data_read got %h want %h", data_read, exp_v);
      end
      rw_addr = 32'd3 + MEM_DEPTH;
      sb.push_back(32'hDEAD_BEEF);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (data_read !== exp_v) begin
         mismatched++; $display("FAIL data_wrap got %h want %h", data_read, exp_v);
      end
      op2_en = 1'b0;
      sb.push_back(32'd0);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (data_read !== exp_v) begin
         mismatched++; $display("FAIL data_disabled got %h want %h", data_read, exp_v);
      end
      op2_en = 1'b1; op2_rw = 1'b1; rw_addr = 32'd3;
      sb.push_back(32'd0);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (data_read !== exp_v) begin
         mismatched++; $display("FAIL data_during_write got %h want %h", data_read, exp_v);
      end
      op2_en = 1'b0; op2_rw = 1'b0;
   endtask

   task automatic test_instruction_port();
      mem_write(32'd1, 32'h2A00_0007);
      read_pc = 32'd1;
      sb.push_back(32'h2A00_0007);
      sb.push_back(32'd1); sb.push_back(32'd1); sb.push_back(32'd1); sb.push_back(32'd7);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (instruction !== exp_v) begin
         mismatched++; $display("FAIL instr got %h want %h", instruction, exp_v);
      end
      exp_v = sb.pop_front(); compared++;
      if (32'(get_opcode(instruction)) !== exp_v) begin
         mismatched++; $display("FAIL dec_opcode got %0d want %0d", get_opcode(instruction), exp_v);
      end
      exp_v = sb.pop_front(); compared++;
      if (32'(get_src(instruction)) !== exp_v) begin
         mismatched++; $display("FAIL dec_src got %0d want %0d", get_src(instruction), exp_v);
      end
      exp_v = sb.pop_front(); compared++;
      if (32'(get_dst(instruction)) !== exp_v) begin
         mismatched++; $display("FAIL dec_dst got %0d want %0d", get_dst(instruction), exp_v);
      end
      exp_v = sb.pop_front(); compared++;
      if (32'(get_imm(instruction)) !== exp_v) begin
         mismatched++; $display("FAIL dec_imm got %0d want %0d", get_imm(instruction), exp_v);
      end
      // same-address write: old word visible until the edge
      read_pc = 32'd3;
      op2_en = 1'b1; op2_rw = 1'b1; rw_addr = 32'd3; data_write = 32'h0BAD_F00D;
      sb.push_back(32'hDEAD_BEEF);
      #1;
      exp_v = sb.pop_front(); compared++;
      if (instruction !== exp_v) begin
         mismatched++; $display("FAIL instr_old_word got %h want %h", instruction, exp_v);
      end
      tick();
      op2_en = 1'b0; op2_rw = 1'b0;
      sb.push_back(32'h0BAD_F00D);
      exp_v = sb.pop_front(); compared++;
      if (instruction !== exp_v) begin
         mismatched++; $display("FAIL instr_new_word got %h want %h", instruction, exp_v);
      end
   endtask

   initial begin
      rst = 1'b1; m_clear = 1'b0; op2_en = 1'b0; op2_rw = 1'b0; opwrite = 1'b0;
      read_pc = '0; rw_addr = '0; data_write = '0;
      reg_write = '0; src_1 = '0; src_2 = '0; reg_data = '0;
      alu_rs = '0; alu_rt = '0; alu_op = '0;
      tick();
      rst = 1'b0;
      test_reset();
      test_mem_clear();
      test_alu();
      test_registers();
      test_data_port();
      test_instruction_port();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
